// File: rtl/regfile_wr_decoder.sv
// Registered one-hot write-strobe generator for a small register file (IDLE -> STROBE -> DONE).
// Build macro REG0_PROTECT_EN makes register 0 read-only: requests to it are rejected with an err pulse.
module regfile_wr_decoder #(
    parameter int ADDR_W        = 2,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en_n,
    input  logic                    req_valid,
    input  logic [ADDR_W-1:0]       addr,
    output logic                    req_ready,
    output logic [(2**ADDR_W)-1:0]  we,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int N = 2**ADDR_W;
    localparam logic [7:0] STROBE_INIT = 8'(STROBE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       state_r, state_s;
    logic [7:0]   cnt_r, cnt_s;
    logic [N-1:0] we_r, we_s;
    logic         done_r, done_s;
    logic         err_r, err_s;
    logic         accept_s;

    function automatic logic [N-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [N-1:0] v;
        v    = {N{1'b0}};
        v[a] = 1'b1;
        return v;
    endfunction

    // Handshake: a request is only seen while idle and enabled.
    always_comb begin
        req_ready = (state_r == IDLE) && (en_n == 1'b0);
        accept_s  = req_valid && req_ready;
    end

    // Next-state and next-output logic; strobe value is held by re-loading we_r.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        we_s    = {N{1'b0}};
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef REG0_PROTECT_EN
                    if (addr == {ADDR_W{1'b0}}) begin
                        state_s = DONE;
                        err_s   = 1'b1;
                    end else begin
                        state_s = STROBE;
                        we_s    = onehot(addr);
                        cnt_s   = STROBE_INIT;
                    end
`else
                    state_s = STROBE;
                    we_s    = onehot(addr);
                    cnt_s   = STROBE_INIT;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            STROBE: begin
                if (en_n) begin
                    // disable mid-write aborts silently
                    state_s = IDLE;
                    cnt_s   = 8'd0;
                end else if (cnt_r == 8'd0) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                    we_s  = we_r;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            we_r    <= {N{1'b0}};
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            we_r    <= we_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign we   = we_r;
    assign done = done_r;
    assign err  = err_r;
    assign busy = (state_r != IDLE);

endmodule
